// File: rtl/frame_pad_insert.sv
// Embeds an IN_ROWS x IN_COLS window stream into an OUT_ROWS x OUT_COLS frame.
// Pixels outside the window are filled with PAD_VALUE. The output stage is a single register slice.
module frame_pad_insert #(
  parameter int PIXEL_BIT_WIDTH = 12,
  parameter int IN_ROWS  = 20,
  parameter int IN_COLS  = 20,
  parameter int OUT_ROWS = 40,
  parameter int OUT_COLS = 40,
  parameter int Y_1      = 10,
  parameter int X_1      = 10,
  parameter logic [PIXEL_BIT_WIDTH-1:0] PAD_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PIXEL_BIT_WIDTH-1:0] i_pixel_in,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  output logic [PIXEL_BIT_WIDTH-1:0] o_pixel_out,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic                       o_out_sof,
  output logic                       o_out_eol
);

  localparam int XW = $clog2(OUT_COLS + 1);
  localparam int YW = $clog2(OUT_ROWS + 1);
  localparam logic [XW-1:0] X_LO   = XW'(X_1);
  localparam logic [XW-1:0] X_HI   = XW'(X_1 + IN_COLS);
  localparam logic [XW-1:0] X_LAST = XW'(OUT_COLS - 1);
  localparam logic [YW-1:0] Y_LO   = YW'(Y_1);
  localparam logic [YW-1:0] Y_HI   = YW'(Y_1 + IN_ROWS);
  localparam logic [YW-1:0] Y_LAST = YW'(OUT_ROWS - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                       r_state;
  logic [XW-1:0]                r_x;
  logic [YW-1:0]                r_y;
  logic [PIXEL_BIT_WIDTH-1:0]   r_pixel;
  logic                         r_valid;
  logic                         r_sof;
  logic                         r_eol;

  logic w_in_win;
  logic w_load_en;
  logic w_load;
  logic w_last_x;
  logic w_last_y;

  assign w_in_win  = (r_y >= Y_LO) && (r_y < Y_HI) && (r_x >= X_LO) && (r_x < X_HI);
  assign w_load_en = !r_valid || i_out_ready;
  assign w_last_x  = (r_x == X_LAST);
  assign w_last_y  = (r_y == Y_LAST);
  // A window beat waits for input; a pad beat never does.
  assign w_load    = (r_state == ACTIVE) && w_load_en && (!w_in_win || i_in_valid);

  assign o_in_ready  = !reset && (r_state == ACTIVE) && w_in_win && w_load_en;
  assign o_pixel_out = r_pixel;
  assign o_out_valid = r_valid;
  assign o_out_sof   = r_sof;
  assign o_out_eol   = r_eol;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_pixel <= '0;
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_eol   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_load_en) r_valid <= 1'b0;
          if (i_in_valid) r_state <= ACTIVE;
        end
        ACTIVE: begin
          if (w_load) begin
            r_pixel <= w_in_win ? i_pixel_in : PAD_VALUE;
            r_valid <= 1'b1;
            r_sof   <= (r_x == '0) && (r_y == '0);
            r_eol   <= w_last_x;
            if (w_last_x) begin
              r_x <= '0;
              if (w_last_y) begin
                r_y     <= '0;
                r_state <= IDLE;
              end else begin
                r_y <= r_y + 1'b1;
              end
            end else begin
              r_x <= r_x + 1'b1;
            end
          end else if (w_load_en) begin
            r_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
